// File: rtl/li_expander_if.sv
`default_nettype none
// ============================================================================
//  Module   : li_expander_if
//  Brief    : Request/response bundle for the load-immediate expander.
//             The request side carries a destination register and a 32-bit
//             constant; the response side streams encoded MIPS words.
//  Revision : 1.0 - initial release
// ============================================================================
interface li_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  // Requester / word consumer side
  modport master (
    output in_valid, in_rt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last
  );

  // Expander side
  modport slave (
    input  in_valid, in_rt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last
  );
endinterface
`default_nettype wire

// File: rtl/li_expander.sv
`default_nettype none
// ============================================================================
//  Module   : li_expander
//  Brief    : Expands a 32-bit load-immediate into one or two MIPS words
//             (NOP, ADDIU, LUI, or LUI+ORI). One request in flight; the
//             output word is registered and held under back-pressure.
//  Revision : 1.0 - initial release
// ============================================================================
module li_expander #(
  parameter bit USE_AT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  li_expander_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONE  = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_LO   = 2'd3;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ori_q,   ori_d;     // second word parked while the LUI is pending
  logic        last_q,  last_d;

  logic        w_accept;
  logic        w_consume;
  logic        w_fits16;
  logic [4:0]  w_dst;
  logic [31:0] w_addiu;
  logic [31:0] w_lui;
  logic [31:0] w_ori;

  assign w_accept  = bus.in_valid & (state_q == S_IDLE);
  assign w_consume = bus.out_valid & bus.out_ready;

  // Constant fits a sign-extended 16-bit field when bits 31..15 agree.
  assign w_fits16 = (&bus.in_imm[31:15]) | ~(|bus.in_imm[31:15]);
  assign w_dst    = USE_AT ? 5'd1 : bus.in_rt;
  assign w_addiu  = {OP_ADDIU, 5'd0, bus.in_rt, bus.in_imm[15:0]};
  assign w_lui    = {OP_LUI, 5'd0, w_dst, bus.in_imm[31:16]};
  assign w_ori    = {OP_ORI, w_dst, bus.in_rt, bus.in_imm[15:0]};

  // Next-state: classify on acceptance, step through the words on consumption.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ori_d   = ori_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          last_d = 1'b1;
          if (bus.in_rt == 5'd0) begin
            state_d = S_ONE;
            instr_d = 32'h0000_0000;
          end else if (w_fits16) begin
            state_d = S_ONE;
            instr_d = w_addiu;
          end else if (bus.in_imm[15:0] == 16'h0000) begin
            state_d = S_HI;
            instr_d = w_lui;
          end else begin
            state_d = S_HI;
            instr_d = w_lui;
            ori_d   = w_ori;
            last_d  = 1'b0;
          end
        end
      end
      S_HI: begin
        if (w_consume) begin
          if (last_q) begin
            state_d = S_IDLE;
            instr_d = 32'h0000_0000;
            last_d  = 1'b0;
          end else begin
            state_d = S_LO;
            instr_d = ori_q;
            last_d  = 1'b1;
          end
        end
      end
      S_ONE, S_LO: begin
        if (w_consume) begin
          state_d = S_IDLE;
          instr_d = 32'h0000_0000;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        instr_d = 32'h0000_0000;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any half-emitted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= 32'h0000_0000;
      ori_q   <= 32'h0000_0000;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ori_q   <= ori_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q != S_IDLE);
  assign bus.out_instr = instr_q;
  assign bus.out_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_li_expander.sv
`default_nettype none
// ============================================================================
//  Module   : tb_li_expander
//  Brief    : Self-checking bench. Two expanders (USE_AT=0 and USE_AT=1) see
//             identical stimulus; each output word is compared against a
//             reference model computed from the instruction-selection rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_li_expander;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  li_expander_if bus0 ();
  li_expander_if bus1 ();

  li_expander #(.USE_AT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  li_expander #(.USE_AT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the instruction sequence from the value of the constant.
  function automatic int expand(input logic [4:0] rt, input logic [31:0] imm,
                                input bit use_at,
                                output logic [31:0] w0, output logic [31:0] w1);
    int         simm;
    logic [4:0] d;
    simm = int'(imm);
    d    = use_at ? 5'd1 : rt;
    w0   = 32'h0;
    w1   = 32'h0;
    if (rt == 5'd0) begin
      return 1;
    end else if (simm >= -32768 && simm <= 32767) begin
      w0 = {6'd9, 5'd0, rt, imm[15:0]};
      return 1;
    end else if (imm % 32'h10000 == 32'h0) begin
      w0 = {6'd15, 5'd0, d, imm[31:16]};
      return 1;
    end
    w0 = {6'd15, 5'd0, d, imm[31:16]};
    w1 = {6'd13, d, rt, imm[15:0]};
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid0"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, "_valid1"}, 32'(bus1.out_valid), 32'd0);
    chk({tag, "_ready0"}, 32'(bus0.in_ready),  32'd1);
    chk({tag, "_ready1"}, 32'(bus1.in_ready),  32'd1);
    chk({tag, "_instr0"}, bus0.out_instr,      32'd0);
    chk({tag, "_instr1"}, bus1.out_instr,      32'd0);
    chk({tag, "_last0"},  32'(bus0.out_last),  32'd0);
    chk({tag, "_last1"},  32'(bus1.out_last),  32'd0);
  endtask

  task automatic drive_req(input logic v, input logic [4:0] rt, input logic [31:0] imm);
    bus0.in_valid = v;  bus0.in_rt = rt;  bus0.in_imm = imm;
    bus1.in_valid = v;  bus1.in_rt = rt;  bus1.in_imm = imm;
  endtask

  // Called at a falling edge with both expanders idle. Junk requests are
  // held on the input while busy to prove they are neither accepted nor
  // allowed to disturb the captured operands.
  task automatic run_req(input string tag, input logic [4:0] rt,
                         input logic [31:0] imm, input int stall);
    logic [31:0] e0 [2];
    logic [31:0] e1 [2];
    int          n;
    n = expand(rt, imm, 1'b0, e0[0], e0[1]);
    void'(expand(rt, imm, 1'b1, e1[0], e1[1]));
    chk({tag, "_inready"}, 32'(bus0.in_ready & bus1.in_ready), 32'd1);
    drive_req(1'b1, rt, imm);
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b1, 5'($urandom), $urandom);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s <= stall; s++) begin
        bus0.out_ready = (s == stall);
        bus1.out_ready = (s == stall);
        chk($sformatf("%s_w%0d_s%0d_valid", tag, i, s),
            32'({bus0.out_valid, bus1.out_valid}), 32'd3);
        chk($sformatf("%s_w%0d_s%0d_instr0", tag, i, s), bus0.out_instr, e0[i]);
        chk($sformatf("%s_w%0d_s%0d_instr1", tag, i, s), bus1.out_instr, e1[i]);
        chk($sformatf("%s_w%0d_s%0d_last", tag, i, s),
            32'({bus0.out_last, bus1.out_last}), (i == n - 1) ? 32'd3 : 32'd0);
        chk($sformatf("%s_w%0d_s%0d_busy", tag, i, s),
            32'({bus0.in_ready, bus1.in_ready}), 32'd0);
        @(negedge clk);
      end
    end
    drive_req(1'b0, 5'd0, 32'd0);
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    chk_idle({tag, "_done"});
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] imm;
    logic [4:0]  rt;
    int          cls;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_req(1'b0, 5'd0, 32'd0);
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed words from the instruction-selection rules
    run_req("addiu_m1",   5'd8, 32'hFFFF_FFFF, 0);
    run_req("addiu_7fff", 5'd8, 32'h0000_7FFF, 0);
    run_req("pair_8000",  5'd8, 32'h0000_8000, 0);
    run_req("lui_only",   5'd8, 32'h1234_0000, 0);
    run_req("nop_rt0",    5'd0, 32'h1234_5678, 0);
    run_req("pair_rt9",   5'd9, 32'h1234_5678, 0);
    run_req("addiu_neg",  5'd3, 32'hFFFF_8000, 0);
    run_req("neg_pair",   5'd3, 32'hFFFF_7FFF, 0);
    run_req("zero",       5'd5, 32'h0000_0000, 0);
    run_req("stall3",     5'd8, 32'h1234_5678, 3);

    // Reset while the LUI word is waiting to be consumed
    drive_req(1'b1, 5'd8, 32'h1234_5678);
    @(negedge clk);
    drive_req(1'b0, 5'd0, 32'd0);
    chk("rst_pend_valid", 32'(bus0.out_valid), 32'd1);
    chk("rst_pend_instr", bus0.out_instr, 32'h3C08_1234);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    @(negedge clk);
    chk_idle("rst_held");
    rst_n = 1'b1;
    run_req("post_rst", 5'd2, 32'h0000_0005, 0);

    // Randomized requests across all classes
    for (int k = 0; k < 40; k++) begin
      cls = int'($urandom_range(0, 3));
      rt  = 5'($urandom_range(1, 31));
      r   = $urandom;
      case (cls)
        0:       imm = $urandom;
        1:       imm = {{16{r[15]}}, r[15:0]};
        2:       imm = {r[15:0], 16'h0000};
        default: begin imm = r; rt = 5'd0; end
      endcase
      run_req($sformatf("rnd%0d", k), rt, imm, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/li_expander.md
LI_EXPANDER -- requirements
Module: li_expander

Interface
REQ-001 SHALL have parameter USE_AT, default 0, meaning: when 1, the upper half is loaded into $at (reg 1) and ORI reads $at; when 0, the upper half is loaded into rt and ORI reads rt.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: request accepted when in_valid and in_ready are both high on a clock edge.
REQ-006 SHALL have port in_rt, input, 5: destination register number.
REQ-007 SHALL have port in_imm, input, 32: constant to load.
REQ-008 SHALL have port out_valid, output, 1: instr is valid.
REQ-009 SHALL have port out_ready, input, 1: word consumed when out_valid and out_ready are both high on a clock edge.
REQ-010 SHALL have port out_instr, output, 32: encoded MIPS instruction word.
REQ-011 SHALL have port out_last, output, 1: marks the final word of the current expansion.

Function
REQ-012 SHALL expand a 32-bit load-immediate into 1 or 2 MIPS words; this is the inverse of the 16->32 sign-extend used in decode.
REQ-013 SHALL capture in_rt and in_imm on acceptance; later input changes have no effect until the next acceptance.
REQ-014 SHALL drive in_ready high only in state IDLE, so there is at most one request in flight.
REQ-015 SHALL use these states:
- IDLE
- ONE: single word, out_last=1
- HI: LUI word, out_last=0 unless LO is not needed
- LO: ORI word, out_last=1
REQ-016 SHALL classify the request and take the first matching case:
- rt==0: emit 0x00000000 (NOP) in ONE.
- imm[31:15] all equal (fits in signed 16 bits): emit ADDIU rt,$0,imm[15:0] = {6'b001001,5'd0,rt,imm[15:0]} in ONE.
- imm[15:0]==0: emit LUI d,imm[31:16] = {6'b001111,5'd0,d,imm[31:16]} in HI with out_last=1, then return to IDLE.
- otherwise: emit LUI in HI, then ORI rt,d,imm[15:0] = {6'b001101,d,rt,imm[15:0]} in LO.
- In all cases d = (USE_AT ? 5'd1 : rt).
REQ-017 SHALL assert out_valid on the first clock edge after acceptance (latency of 1 cycle), with out_instr registered.
REQ-018 SHALL advance HI->LO on consumption of the LUI word, and advance ONE, LO, or final HI -> IDLE on consumption of that word.
REQ-019 SHALL hold out_instr and out_last stable while out_valid=1 and out_ready=0, with no cap on the stall length.
REQ-020 SHALL never drop out_valid before the word is consumed.
REQ-021 SHALL keep consecutive words of a pair back-to-back when out_ready stays high (LUI on cycle n, ORI on cycle n+1).
REQ-022 SHALL give the next request its first word no earlier than 1 cycle after the last word of the prior request is consumed.
REQ-023 SHALL drive out_valid=0 in IDLE; out_instr and out_last are don't-care there but SHALL be driven 0.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, out_instr=0, out_last=0, in_ready=1, independent of clk.
REQ-025 SHALL discard any partially emitted pair when reset asserts mid-expansion; no ORI is emitted after release.
REQ-026 SHALL accept a new request on the first clock edge after rst_n releases.

Verification
REQ-027 SHALL cover: rt=8, imm=0xFFFFFFFF -> one word 0x2408FFFF with out_last=1; rt=8, imm=0x00007FFF -> 0x24087FFF.
REQ-028 SHALL cover: rt=8, imm=0x00008000, USE_AT=0 -> 0x3C080000 (last=0) then 0x35088000 (last=1) on consecutive cycles.
REQ-029 SHALL cover: rt=8, imm=0x12340000 -> single 0x3C081234 with out_last=1; rt=0, imm=0x12345678 -> single 0x00000000.
REQ-030 SHALL cover: USE_AT=1, rt=9, imm=0x12345678 -> 0x3C011234 then 0x34295678.
REQ-031 SHALL cover: a pair with out_ready held low for 3 cycles on each word -> words stable while stalled, in_ready=0 throughout, no duplicated or lost word.
REQ-032 SHALL cover: rst_n pulsed low while the LUI word is pending -> out_valid=0 at once, no ORI afterwards, next request (rt=2, imm=5) -> 0x24020005.
